// File: rtl/timed_job_arbiter_if.sv
// Requester and engine signals of the timed job arbiter, bundled for port hookup.
// req: level request. gnt: one-hot owner, held from LAUNCH until job end. job_done/job_aborted:
// one-cycle pulses to the owner. eng_go/eng_kill: one-cycle engine commands, never together.
// eng_done: one-cycle engine pulse, honoured only while a job is running.
interface timed_job_arbiter_if #(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] cancel;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] job_done;
  logic [N_REQ-1:0] job_aborted;
  logic             busy;
  logic             eng_go;
  logic             eng_kill;
  logic             eng_done;

  modport slave (
    input  req, cancel, eng_done,
    output gnt, job_done, job_aborted, busy, eng_go, eng_kill
  );

  modport master (
    output req, cancel, eng_done,
    input  gnt, job_done, job_aborted, busy, eng_go, eng_kill
  );
endinterface

// File: rtl/timed_job_arbiter.sv
// Round-robin arbiter sharing one go/kill/done engine among N_REQ requesters,
// with per-job watchdog, owner cancel, kill recovery gap and a post-reset engine flush.
module timed_job_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 120,
  parameter int RECOVER = 2,
  parameter int TO_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  timed_job_arbiter_if.slave   bus,
  output logic [2:0]           dbg_state
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FLUSH  = 3'd1,
    S_DRAIN  = 3'd2,
    S_IDLE   = 3'd3,
    S_LAUNCH = 3'd4,
    S_RUN    = 3'd5,
    S_KILL   = 3'd6
  } state_t;

  state_t            state, state_n;
  logic [IW-1:0]     ptr, ptr_n;
  logic [IW-1:0]     owner, owner_n;
  logic [IW-1:0]     sel, next_ptr;
  logic              sel_vld;
  logic [TO_W-1:0]   cnt;
  logic [N_REQ-1:0]  gnt_r, gnt_n;
  logic [N_REQ-1:0]  done_r, done_n;
  logic [N_REQ-1:0]  abort_r, abort_n;
  logic              busy_r, go_r, kill_r;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int unsigned b);
    int unsigned s;
    s = 32'(a) + b;
    if (s >= 32'(N_REQ)) s = s - 32'(N_REQ);
    return IW'(s);
  endfunction

  assign next_ptr = wrap_add(owner, 1);

  // Descending scan so the smallest offset from the pointer is the one that sticks.
  always_comb begin
    sel     = ptr;
    sel_vld = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (bus.req[wrap_add(ptr, i)]) begin
        sel     = wrap_add(ptr, i);
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    owner_n = owner;
    gnt_n   = gnt_r;
    done_n  = '0;
    abort_n = '0;
    case (state)
      S_RST:   state_n = S_FLUSH;
      S_FLUSH: state_n = S_DRAIN;
      S_DRAIN: if (cnt == TO_W'(RECOVER - 1)) state_n = S_IDLE;
      S_IDLE: begin
        if (sel_vld) begin
          owner_n    = sel;
          gnt_n      = '0;
          gnt_n[sel] = 1'b1;
          state_n    = S_LAUNCH;
        end
      end
      S_LAUNCH: state_n = S_RUN;
      S_RUN: begin
        // Completion outranks both cancel and watchdog expiry in the same cycle.
        if (bus.eng_done) begin
          done_n  = gnt_r;
          gnt_n   = '0;
          ptr_n   = next_ptr;
          state_n = S_IDLE;
        end else if (bus.cancel[owner] || (cnt == TO_W'(TIMEOUT - 1))) begin
          state_n = S_KILL;
        end
      end
      S_KILL: begin
        abort_n = gnt_r;
        gnt_n   = '0;
        ptr_n   = next_ptr;
        state_n = S_DRAIN;
      end
      default: begin
        gnt_n   = '0;
        state_n = S_FLUSH;
      end
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the state it belongs to.
  // cnt restarts on every state change: it is the watchdog in RUN and the gap counter in DRAIN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_RST;
      ptr     <= '0;
      owner   <= '0;
      cnt     <= '0;
      gnt_r   <= '0;
      done_r  <= '0;
      abort_r <= '0;
      busy_r  <= 1'b0;
      go_r    <= 1'b0;
      kill_r  <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      owner   <= owner_n;
      cnt     <= (state_n != state) ? '0 : cnt + TO_W'(1);
      gnt_r   <= gnt_n;
      done_r  <= done_n;
      abort_r <= abort_n;
      busy_r  <= (state_n != S_IDLE);
      go_r    <= (state_n == S_LAUNCH);
      kill_r  <= (state_n == S_FLUSH) || (state_n == S_KILL);
    end
  end

  assign bus.gnt         = gnt_r;
  assign bus.job_done    = done_r;
  assign bus.job_aborted = abort_r;
  assign bus.busy        = busy_r;
  assign bus.eng_go      = go_r;
  assign bus.eng_kill    = kill_r;
  assign dbg_state       = state;
endmodule

// File: tb/tb_timed_job_arbiter.sv
// Directed bench for timed_job_arbiter: behavioural engine, grant-order scoreboard,
// per-cycle invariant monitor and hand-timed job scenarios.
module tb_timed_job_arbiter;
  localparam int N       = 4;
  localparam int TIMEOUT = 120;
  localparam int RECOVER = 2;
  localparam int ENG_LAT = 101;

  // clock / reset
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  timed_job_arbiter_if #(.N_REQ(N)) bus();
  logic [2:0] dbg_state;
  logic model_done, man_done, eng_auto;
  assign bus.eng_done = model_done | man_done;

  timed_job_arbiter #(
    .N_REQ(N), .TIMEOUT(TIMEOUT), .RECOVER(RECOVER), .TO_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) sample();
  endtask

  // which: 0 eng_go, 1 eng_kill, 2 job_done, 3 job_aborted
  task automatic wait_for(input int which, input int budget, input string tag, output int at);
    logic hit;
    hit = 1'b0;
    at  = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      sample();
      case (which)
        0:       hit = bus.eng_go;
        1:       hit = bus.eng_kill;
        2:       hit = |bus.job_done;
        default: hit = |bus.job_aborted;
      endcase
    end
    if (hit) at = cyc;
    check(tag, 32'(hit), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    for (int i = 0; i < budget && bus.busy; i++) sample();
    check(tag, 32'(bus.busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wait_cycles(2);
    rst = 1'b0;
    sample();
    wait_idle(10, "reset_idle");
  endtask

  // Behavioural engine: done pulse ENG_LAT cycles after go, forgotten on kill.
  initial begin
    int   eng_cnt;
    logic go_s, kill_s;
    eng_cnt    = 0;
    model_done = 1'b0;
    forever begin
      @(negedge clk);
      go_s   = bus.eng_go;
      kill_s = bus.eng_kill;
      @(posedge clk);
      #1;
      model_done = 1'b0;
      if (kill_s) eng_cnt = 0;
      else if (go_s && eng_auto) eng_cnt = ENG_LAT - 1;
      else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) model_done = 1'b1;
      end
    end
  end

  // scoreboard: expected grant per eng_go, plus invariants every cycle
  logic [N-1:0] exp_q[$];
  int n_go = 0, n_kill = 0, n_done = 0, n_abort = 0;
  initial begin
    logic [N-1:0] prev_gnt, exp_g;
    prev_gnt = '0;
    forever begin
      @(negedge clk);
      check("gnt_onehot0", 32'($onehot0(bus.gnt)), 1);
      check("go_kill_excl", 32'(bus.eng_go & bus.eng_kill), 0);
      check("done_abort_excl", 32'(|(bus.job_done & bus.job_aborted)), 0);
      check("pulse_owner", 32'((bus.job_done | bus.job_aborted) & ~prev_gnt), 0);
      check("go_once_per_gnt", 32'(bus.eng_go && (prev_gnt != '0)), 0);
      if (bus.eng_go) begin
        n_go++;
        exp_g = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check("grant_order", 32'(bus.gnt), 32'(exp_g));
      end
      if (bus.eng_kill) n_kill++;
      if (|bus.job_done) n_done++;
      if (|bus.job_aborted) n_abort++;
      prev_gnt = bus.gnt;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000ns");
    $fatal(1, "bench time limit");
  end

  initial begin
    int l, l2, at, abort_at, got;
    int b_go, b_kill, b_done, b_abort;
    rst        = 1'b1;
    bus.req    = '0;
    bus.cancel = '0;
    man_done   = 1'b0;
    eng_auto   = 1'b1;

    // T1: reset, flush, single job on requester 0
    wait_cycles(3);
    check("rst_gnt", 32'(bus.gnt), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_kill", 32'(bus.eng_kill), 0);
    check("rst_go", 32'(bus.eng_go), 0);
    check("rst_done", 32'(bus.job_done), 0);
    b_kill = n_kill;
    rst = 1'b0;
    sample();
    check("flush_kill", 32'(bus.eng_kill), 1);
    check("flush_busy", 32'(bus.busy), 1);
    check("flush_no_abort", 32'(bus.job_aborted), 0);
    sample();
    check("drain1_kill", 32'(bus.eng_kill), 0);
    check("drain1_busy", 32'(bus.busy), 1);
    sample();
    check("drain2_busy", 32'(bus.busy), 1);
    sample();
    check("idle_busy", 32'(bus.busy), 0);
    exp_q.push_back(4'b0001);
    bus.req = 4'b0001;
    sample();
    check("t1_go", 32'(bus.eng_go), 1);
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    l = cyc;
    bus.req = '0;
    wait_for(2, 150, "t1_done_seen", at);
    check("t1_done_val", 32'(bus.job_done), 32'h1);
    check("t1_done_lat", 32'(at - l), 102);
    check("t1_gnt_clr", 32'(bus.gnt), 0);
    sample();
    check("t1_busy_low", 32'(bus.busy), 0);
    check("t1_done_one_cycle", 32'(bus.job_done), 0);
    wait_cycles(3);
    check("t1_busy_stays_low", 32'(bus.busy), 0);
    check("t1_go_count", 32'(n_go), 1);
    check("t1_kill_count", 32'(n_kill - b_kill), 1);
    check("t1_abort_count", 32'(n_abort), 0);

    // T2: all four requesting, round-robin 0,1,2,3,0
    do_reset();
    b_go = n_go; b_done = n_done; b_abort = n_abort;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    exp_q.push_back(4'b0001);
    bus.req = 4'b1111;
    got = 0;
    for (int i = 0; i < 700 && got < 5; i++) begin
      sample();
      if (|bus.job_done) begin
        got++;
        if (got == 5) bus.req = '0;
      end
    end
    check("t2_jobs_done", 32'(got), 5);
    wait_idle(10, "t2_idle");
    check("t2_go_count", 32'(n_go - b_go), 5);
    check("t2_done_count", 32'(n_done - b_done), 5);
    check("t2_abort_count", 32'(n_abort - b_abort), 0);
    check("t2_queue_empty", 32'(exp_q.size()), 0);

    // T3: pointer at 1; owner 2 cancels 30 cycles in, requester 3 is next
    b_done = n_done; b_abort = n_abort; b_kill = n_kill;
    exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000);
    bus.req = 4'b1100;
    wait_for(0, 10, "t3_go", l);
    check("t3_gnt", 32'(bus.gnt), 32'h4);
    bus.req = 4'b1000;
    wait_cycles(30);
    bus.cancel = 4'b0100;
    sample();
    bus.cancel = '0;
    check("t3_kill", 32'(bus.eng_kill), 1);
    check("t3_kill_gnt_held", 32'(bus.gnt), 32'h4);
    sample();
    check("t3_abort", 32'(bus.job_aborted), 32'h4);
    check("t3_gnt_clr", 32'(bus.gnt), 0);
    check("t3_kill_one_cycle", 32'(bus.eng_kill), 0);
    check("t3_drain_busy", 32'(bus.busy), 1);
    wait_for(0, 10, "t3_regrant", at);
    check("t3_regrant_gap", 32'(at - l), 35);
    check("t3_gnt2", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    wait_for(2, 150, "t3_done2", at);
    check("t3_done2_val", 32'(bus.job_done), 32'h8);
    wait_idle(10, "t3_idle");
    check("t3_done_count", 32'(n_done - b_done), 1);
    check("t3_abort_count", 32'(n_abort - b_abort), 1);
    check("t3_kill_count", 32'(n_kill - b_kill), 1);

    // T4: pointer at 0; engine silent -> watchdog, then done+cancel together
    b_abort = n_abort;
    eng_auto = 1'b0;
    exp_q.push_back(4'b0001);
    exp_q.push_back(4'b0001);
    bus.req = 4'b0001;
    wait_for(0, 10, "t4_go", l);
    wait_for(1, 200, "t4_kill", at);
    check("t4_kill_lat", 32'(at - l), TIMEOUT + 1);
    check("t4_kill_gnt_held", 32'(bus.gnt), 32'h1);
    sample();
    check("t4_abort", 32'(bus.job_aborted), 32'h1);
    abort_at = cyc;
    wait_for(0, 10, "t4_go2", l2);
    check("t4_regrant_gap", 32'(l2 - abort_at), 3);
    bus.req = '0;
    wait_cycles(5);
    bus.cancel = 4'b0001;
    man_done   = 1'b1;
    sample();
    bus.cancel = '0;
    man_done   = 1'b0;
    check("t4_done_wins", 32'(bus.job_done), 32'h1);
    check("t4_no_abort", 32'(bus.job_aborted), 0);
    check("t4_busy_low", 32'(bus.busy), 0);
    sample();
    check("t4_no_kill", 32'(bus.eng_kill), 0);
    check("t4_no_late_abort", 32'(bus.job_aborted), 0);
    check("t4_abort_count", 32'(n_abort - b_abort), 1);
    eng_auto = 1'b1;

    // T5: stray inputs in IDLE, non-owner cancel, reset mid-job
    b_done = n_done; b_abort = n_abort; b_kill = n_kill; b_go = n_go;
    bus.cancel = 4'b1111;
    man_done   = 1'b1;
    sample();
    bus.cancel = '0;
    man_done   = 1'b0;
    check("t5_idle_busy", 32'(bus.busy), 0);
    check("t5_idle_gnt", 32'(bus.gnt), 0);
    check("t5_idle_pulses", 32'(bus.job_done | bus.job_aborted), 0);
    sample();
    check("t5_idle_go", 32'(bus.eng_go), 0);
    check("t5_idle_kill", 32'(bus.eng_kill), 0);
    check("t5_idle_go_count", 32'(n_go - b_go), 0);
    exp_q.push_back(4'b0010);
    bus.req = 4'b0010;
    wait_for(0, 10, "t5_go", l);
    check("t5_gnt", 32'(bus.gnt), 32'h2);
    bus.req    = '0;
    bus.cancel = 4'b1101;
    wait_cycles(50);
    check("t5_nonowner_busy", 32'(bus.busy), 1);
    check("t5_nonowner_gnt", 32'(bus.gnt), 32'h2);
    check("t5_nonowner_no_kill", 32'(n_kill - b_kill), 0);
    bus.cancel = '0;
    rst = 1'b1;
    sample();
    check("t5_rst_gnt", 32'(bus.gnt), 0);
    check("t5_rst_busy", 32'(bus.busy), 0);
    check("t5_rst_go_kill", 32'({bus.eng_go, bus.eng_kill}), 0);
    check("t5_rst_pulses", 32'(bus.job_done | bus.job_aborted), 0);
    rst = 1'b0;
    sample();
    check("t5_flush_kill", 32'(bus.eng_kill), 1);
    wait_idle(10, "t5_idle_after_rst");
    check("t5_no_done", 32'(n_done - b_done), 0);
    check("t5_no_abort", 32'(n_abort - b_abort), 0);
    exp_q.push_back(4'b0001);
    bus.req = 4'b0011;
    wait_for(0, 10, "t5_go_after_rst", at);
    check("t5_ptr_reset", 32'(bus.gnt), 32'h1);
    bus.req = '0;
    wait_for(2, 150, "t5_done", at);
    check("t5_done_val", 32'(bus.job_done), 32'h1);
    wait_idle(10, "t5_final_idle");

    wait_cycles(2);
    check("final_queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
